// File: rtl/cmd_buf_pkg.sv
// ============================================================================
// Module  : cmd_buf_pkg
// Brief   : Shared types, limits and parity helper for the command buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_buf_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    localparam int MAX_WORDS_PER_CMD = 8;
    localparam int MAX_STALL         = 15;
    localparam int PAR_MAX_W         = 256;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_buf_ram.sv
// ============================================================================
// Module  : cmd_buf_ram
// Brief   : Single-port synchronous RAM, one read or write per cycle,
//           registered read data held until the next read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_buf_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/cmd_buffer_mw.sv
// ============================================================================
// Module  : cmd_buffer_mw
// Brief   : Multi-word command buffer: AHB write/read-back plus a fetch FSM
//           with starvation guard. Optional parity via CMD_BUF_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_buffer_mw
    import cmd_buf_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CMD_DEPTH     = 256,
    parameter int ADDR_W        = $clog2(CMD_DEPTH),
    parameter int WORDS_PER_CMD = 2,
    parameter int STALL_MAX     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_en,
    input  logic [ADDR_W-1:0]                 trans_addr,
    input  logic                              slv_o_valid,
    input  logic                              slv_o_rd0_wr1,
    input  logic [DATA_WIDTH-1:0]             slv_o_wr_data,
    output logic                              slv_i_ready,
    output logic [DATA_WIDTH-1:0]             slv_i_rd_data,
    output logic                              slv_i_rd_valid,
    input  logic                              cmd_rd_en,
    input  logic [ADDR_W-1:0]                 cmd_addr,
    output logic                              cmd_busy,
    output logic                              cmd_rd_valid,
    output logic [DATA_WIDTH*WORDS_PER_CMD-1:0] cmd_out
`ifdef CMD_BUF_PARITY_EN
    ,
    output logic                              cmd_par_err
`endif
);

`ifdef CMD_BUF_PARITY_EN
    localparam int PAR_BIT = 1;
`else
    localparam int PAR_BIT = 0;
`endif
    localparam int RAM_W = DATA_WIDTH + PAR_BIT;
    localparam int KW    = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;

    fetch_state_t            r_state;
    fetch_state_t            w_state_nxt;
    logic [ADDR_W-1:0]       r_base;
    logic [KW-1:0]           r_k;
    logic [3:0]              r_stall;
    logic                    r_ready;
    logic                    r_rd_valid;
    logic                    r_cmd_vld;
    logic [DATA_WIDTH-1:0]   r_cmd [WORDS_PER_CMD];
    logic                    r_ovl_vld;
    logic [KW-1:0]           r_ovl_k;

    logic                    w_acc;
    logic                    w_ahb_rd;
    logic                    w_fetch_rd;
    logic                    w_last;
    logic                    w_throttle;
    logic                    w_busy;
    logic [ADDR_W-1:0]       w_ram_addr;
    logic [RAM_W-1:0]        w_ram_wdata;
    logic [RAM_W-1:0]        w_ram_q;
    logic [DATA_WIDTH-1:0]   w_q_data;

    assign w_acc      = cmd_en & slv_o_valid & r_ready;
    assign w_ahb_rd   = w_acc & ~slv_o_rd0_wr1;
    assign w_fetch_rd = (r_state == FETCH) & ~w_acc;
    assign w_last     = w_fetch_rd & (r_k == KW'(WORDS_PER_CMD - 1));
    // Ready drops on the edge where the stall count reaches STALL_MAX.
    assign w_throttle = (r_state == FETCH) & w_acc & (r_stall == 4'(STALL_MAX - 1));
    assign w_ram_addr = w_acc ? trans_addr : (r_base + ADDR_W'(r_k));
    assign w_q_data   = w_ram_q[DATA_WIDTH-1:0];

`ifdef CMD_BUF_PARITY_EN
    assign w_ram_wdata = {calc_parity(PAR_MAX_W'(slv_o_wr_data)), slv_o_wr_data};
`else
    assign w_ram_wdata = slv_o_wr_data;
`endif

    cmd_buf_ram #(
        .WIDTH (RAM_W),
        .DEPTH (CMD_DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_acc & slv_o_rd0_wr1),
        .i_re    (w_ahb_rd | w_fetch_rd),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_rd_en) w_state_nxt = FETCH;
            FETCH:   if (w_last)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        if (r_state == FETCH) w_busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_k        <= '0;
            r_stall    <= '0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_ovl_vld  <= 1'b0;
            r_ovl_k    <= '0;
            for (int i = 0; i < WORDS_PER_CMD; i++) r_cmd[i] <= '0;
        end else begin
            r_ready    <= ~w_throttle;
            r_rd_valid <= w_ahb_rd;
            r_cmd_vld  <= w_last;
            if (r_state == IDLE && cmd_rd_en) begin
                r_base <= cmd_addr;
                r_k    <= '0;
            end else if (w_fetch_rd) begin
                r_k <= r_k + KW'(1);
            end
            if (r_state == FETCH && w_acc) begin
                r_stall <= r_stall + 4'd1;
            end else begin
                r_stall <= '0;
            end
            // Fetched word lives in the RAM output register for one cycle,
            // then is committed into its slice.
            if (r_ovl_vld) r_cmd[r_ovl_k] <= w_q_data;
            r_ovl_vld <= w_fetch_rd;
            r_ovl_k   <= r_k;
        end
    end

    for (genvar g = 0; g < WORDS_PER_CMD; g++) begin : g_slice
        assign cmd_out[g*DATA_WIDTH +: DATA_WIDTH] =
            (r_ovl_vld && (r_ovl_k == KW'(g))) ? w_q_data : r_cmd[g];
    end

`ifdef CMD_BUF_PARITY_EN
    logic r_par_err;
    logic w_par_bad;

    assign w_par_bad = (r_rd_valid | r_ovl_vld) &
                       (calc_parity(PAR_MAX_W'(w_q_data)) != w_ram_q[DATA_WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_par_bad) begin
            r_par_err <= 1'b1;
        end
    end

    assign cmd_par_err = r_par_err;
`endif

    assign slv_i_ready    = r_ready;
    assign slv_i_rd_valid = r_rd_valid;
    assign slv_i_rd_data  = r_rd_valid ? w_q_data : '0;
    assign cmd_busy       = w_busy;
    assign cmd_rd_valid   = r_cmd_vld;

endmodule

`default_nettype wire

// File: tb/tb_cmd_buffer_mw.sv
// ============================================================================
// Module  : tb_cmd_buffer_mw
// Brief   : Directed self-checking bench for cmd_buffer_mw.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_buffer_mw;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int WPC = 2;

    logic            clk;
    logic            rst;
    logic            cmd_en;
    logic [AW-1:0]   trans_addr;
    logic            slv_o_valid;
    logic            slv_o_rd0_wr1;
    logic [DW-1:0]   slv_o_wr_data;
    logic            slv_i_ready;
    logic [DW-1:0]   slv_i_rd_data;
    logic            slv_i_rd_valid;
    logic            cmd_rd_en;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_busy;
    logic            cmd_rd_valid;
    logic [DW*WPC-1:0] cmd_out;
`ifdef CMD_BUF_PARITY_EN
    logic            cmd_par_err;
`endif

    int n_chk;
    int n_fail;

    cmd_buffer_mw dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_en         (cmd_en),
        .trans_addr     (trans_addr),
        .slv_o_valid    (slv_o_valid),
        .slv_o_rd0_wr1  (slv_o_rd0_wr1),
        .slv_o_wr_data  (slv_o_wr_data),
        .slv_i_ready    (slv_i_ready),
        .slv_i_rd_data  (slv_i_rd_data),
        .slv_i_rd_valid (slv_i_rd_valid),
        .cmd_rd_en      (cmd_rd_en),
        .cmd_addr       (cmd_addr),
        .cmd_busy       (cmd_busy),
        .cmd_rd_valid   (cmd_rd_valid),
        .cmd_out        (cmd_out)
`ifdef CMD_BUF_PARITY_EN
        ,
        .cmd_par_err    (cmd_par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ahb_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic r;
        int   n;
        cmd_en = 1'b1; slv_o_valid = 1'b1; slv_o_rd0_wr1 = 1'b1;
        trans_addr = a; slv_o_wr_data = d;
        n = 0;
        do begin
            r = slv_i_ready;
            tick();
            n++;
        end while (!r && n < 20);
        check_eq("wr_accept", r, 1'b1);
        slv_o_valid = 1'b0;
    endtask

    task automatic ahb_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        logic r;
        int   n;
        cmd_en = 1'b1; slv_o_valid = 1'b1; slv_o_rd0_wr1 = 1'b0;
        trans_addr = a;
        n = 0;
        do begin
            r = slv_i_ready;
            tick();
            n++;
        end while (!r && n < 20);
        slv_o_valid = 1'b0;
        check_eq({tag, "_vld"}, slv_i_rd_valid, 1'b1);
        check_eq({tag, "_data"}, slv_i_rd_data, exp);
        tick();
        check_eq({tag, "_vld_pulse"}, slv_i_rd_valid, 1'b0);
        check_eq({tag, "_data_zero"}, slv_i_rd_data, '0);
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, input logic [DW*WPC-1:0] exp, input string tag);
        int n;
        cmd_rd_en = 1'b1; cmd_addr = a;
        tick();
        cmd_rd_en = 1'b0;
        check_eq({tag, "_busy"}, cmd_busy, 1'b1);
        n = 0;
        while (!cmd_rd_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, 2);
        check_eq({tag, "_data"}, cmd_out, exp);
        check_eq({tag, "_busy_done"}, cmd_busy, 1'b0);
        tick();
        check_eq({tag, "_vld_pulse"}, cmd_rd_valid, 1'b0);
        check_eq({tag, "_hold"}, cmd_out, exp);
    endtask

    initial begin
        logic          r;
        logic          got;
        logic          saw;
        int            idx;
        int            low;
        int            acc_before_low;
        logic [DW*WPC-1:0] cap;

        n_chk = 0; n_fail = 0;
        rst = 1'b1; cmd_en = 1'b0; trans_addr = '0; slv_o_valid = 1'b0;
        slv_o_rd0_wr1 = 1'b0; slv_o_wr_data = '0; cmd_rd_en = 1'b0; cmd_addr = '0;
        tick(); tick(); tick();
        check_eq("rst_ready", slv_i_ready, 1'b0);
        check_eq("rst_rd_data", slv_i_rd_data, '0);
        check_eq("rst_rd_valid", slv_i_rd_valid, 1'b0);
        check_eq("rst_busy", cmd_busy, 1'b0);
        check_eq("rst_cmd_vld", cmd_rd_valid, 1'b0);
        check_eq("rst_cmd_out", cmd_out, '0);
        rst = 1'b0;
        tick();
        check_eq("ready_after_rst", slv_i_ready, 1'b1);

        ahb_wr(8'd10, 32'hA5A5_0001);
        ahb_wr(8'd11, 32'h5A5A_0002);
        do_fetch(8'd10, 64'h5A5A_0002_A5A5_0001, "fetch10");

        ahb_wr(8'd255, 32'h1111_1111);
        ahb_wr(8'd0,   32'h2222_2222);
        do_fetch(8'd255, 64'h2222_2222_1111_1111, "fetch_wrap");

        ahb_rd(8'd10, 32'hA5A5_0001, "rd10");

        // Deselected read and write: nothing may be accepted.
        cmd_en = 1'b0; slv_o_valid = 1'b1; slv_o_rd0_wr1 = 1'b0; trans_addr = 8'd10;
        tick();
        check_eq("nosel_rd_vld", slv_i_rd_valid, 1'b0);
        slv_o_rd0_wr1 = 1'b1; trans_addr = 8'd11; slv_o_wr_data = 32'hFFFF_FFFF;
        tick(); tick();
        check_eq("nosel_rd_vld2", slv_i_rd_valid, 1'b0);
        slv_o_valid = 1'b0;
        ahb_rd(8'd11, 32'h5A5A_0002, "nosel_wr");

        // Fetch 20..21 under continuous AHB write pressure.
        ahb_wr(8'd20, 32'h0000_0020);
        cmd_rd_en = 1'b1; cmd_addr = 8'd20;
        tick();
        cmd_rd_en = 1'b0;
        idx = 0; low = 0; acc_before_low = -1; got = 1'b0; cap = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (idx < 10) begin
                cmd_en = 1'b1; slv_o_valid = 1'b1; slv_o_rd0_wr1 = 1'b1;
                trans_addr    = (idx == 0) ? 8'd21 : 8'(100 + idx);
                slv_o_wr_data = (idx == 0) ? 32'hDEAD_BEEF : 32'(idx);
            end else begin
                slv_o_valid = 1'b0;
            end
            r = slv_i_ready;
            if (!r) begin
                low++;
                if (acc_before_low < 0) acc_before_low = idx;
            end
            tick();
            if (r && idx < 10) idx++;
            if (cmd_rd_valid) begin
                got = 1'b1;
                cap = cmd_out;
            end
        end
        slv_o_valid = 1'b0;
        check_eq("stall_done", got, 1'b1);
        check_eq("stall_first_drop", acc_before_low, 4);
        check_eq("stall_low_cycles", low, 2);
        check_eq("stall_writes", idx, 8);
        check_eq("stall_data", cap, 64'hDEAD_BEEF_0000_0020);
        tick();
        check_eq("stall_ready_back", slv_i_ready, 1'b1);
        ahb_rd(8'd21, 32'hDEAD_BEEF, "rd21");

        // Reset during the first FETCH cycle abandons the fetch.
        cmd_rd_en = 1'b1; cmd_addr = 8'd10;
        tick();
        cmd_rd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", cmd_busy, 1'b0);
        check_eq("midrst_out", cmd_out, '0);
        saw = cmd_rd_valid;
        for (int c = 0; c < 5; c++) begin
            tick();
            saw = saw | cmd_rd_valid;
        end
        check_eq("midrst_no_vld", saw, 1'b0);
        do_fetch(8'd10, 64'h5A5A_0002_A5A5_0001, "refetch10");

`ifdef CMD_BUF_PARITY_EN
        check_eq("par_clean", cmd_par_err, 1'b0);
        dut.u_ram.r_mem[10][DW] = ~dut.u_ram.r_mem[10][DW];
        do_fetch(8'd10, 64'h5A5A_0002_A5A5_0001, "par_fetch");
        check_eq("par_err_set", cmd_par_err, 1'b1);
        tick(); tick(); tick();
        check_eq("par_err_sticky", cmd_par_err, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
